// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: merges hazard, redirect, memory-busy and halt
// requests into prioritised per-stage stall/flush/bubble controls.
module pipe_seq_ctrl #(
   parameter int unsigned LOAD_BUBBLES = 1,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ld_hazard,
   input  logic br_taken,
   input  logic mem_busy,
   input  logic d_halt,
   output logic pc_stall,
   output logic ifid_stall,
   output logic ifid_flush,
   output logic idex_nop,
   output logic idex_stall,
   output logic exmem_stall,
   output logic halted
);

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] LB_INIT    = CNT_W'(LOAD_BUBBLES - 2);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      DRAIN   = 2'd2,
      HALT    = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               ld, br, mb, hlt;

   // Anything other than a clean 1 (including X/Z) reads as inactive.
   assign ld  = (ld_hazard === 1'b1);
   assign br  = (br_taken  === 1'b1);
   assign mb  = (mem_busy  === 1'b1);
   assign hlt = (d_halt    === 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs are gated by rst_n so they drop immediately on reset assertion.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_nop    = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      halted      = 1'b0;

      if (rst_n) begin
         if (state == HALT) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_nop    = 1'b1;
            halted      = 1'b1;
            exmem_stall = mb;
         end else if (mb) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (br) begin
                     ifid_flush = 1'b1;
                     idex_nop   = 1'b1;
                  end else if (ld) begin
                     pc_stall   = 1'b1;
                     ifid_stall = 1'b1;
                     idex_nop   = 1'b1;
                     if (LOAD_BUBBLES > 1) begin
                        state_nxt = LDSTALL;
                        cnt_nxt   = LB_INIT;
                     end
                  end else if (hlt) begin
                     pc_stall   = 1'b1;
                     ifid_stall = 1'b1;
                     idex_nop   = 1'b1;
                     state_nxt  = DRAIN;
                     cnt_nxt    = DRAIN_INIT;
                  end
               end
               LDSTALL: begin
                  if (br) begin
                     ifid_flush = 1'b1;
                     idex_nop   = 1'b1;
                     state_nxt  = RUN;
                     cnt_nxt    = '0;
                  end else begin
                     pc_stall   = 1'b1;
                     ifid_stall = 1'b1;
                     idex_nop   = 1'b1;
                     if (cnt == '0) state_nxt = RUN;
                     else           cnt_nxt   = cnt - CNT_W'(1);
                  end
               end
               DRAIN: begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_nop   = 1'b1;
                  if (cnt == '0) state_nxt = HALT;
                  else           cnt_nxt   = cnt - CNT_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: three parameterisations driven in lockstep and
// compared every cycle against a remaining-cycles reference model.
module tb_pipe_seq_ctrl;

   logic clk;
   logic rst_n;
   logic ld_hazard, br_taken, mem_busy, d_halt;
   wire  [6:0] o0, o1, o2;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference state per instance: bubbles still owed, drain cycles left, halted.
   int lb  [3] = '{3, 2, 1};
   int dc  [3] = '{3, 2, 1};
   int bub [3];
   int drn [3];
   bit hm  [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_nop, idex_stall, exmem_stall, halted}
   pipe_seq_ctrl #(.LOAD_BUBBLES(3), .DRAIN_CYCLES(3)) u_lb3 (
      .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .br_taken(br_taken),
      .mem_busy(mem_busy), .d_halt(d_halt),
      .pc_stall(o0[6]), .ifid_stall(o0[5]), .ifid_flush(o0[4]), .idex_nop(o0[3]),
      .idex_stall(o0[2]), .exmem_stall(o0[1]), .halted(o0[0]));

   pipe_seq_ctrl #(.LOAD_BUBBLES(2), .DRAIN_CYCLES(2)) u_lb2 (
      .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .br_taken(br_taken),
      .mem_busy(mem_busy), .d_halt(d_halt),
      .pc_stall(o1[6]), .ifid_stall(o1[5]), .ifid_flush(o1[4]), .idex_nop(o1[3]),
      .idex_stall(o1[2]), .exmem_stall(o1[1]), .halted(o1[0]));

   pipe_seq_ctrl #(.LOAD_BUBBLES(1), .DRAIN_CYCLES(1)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .br_taken(br_taken),
      .mem_busy(mem_busy), .d_halt(d_halt),
      .pc_stall(o2[6]), .ifid_stall(o2[5]), .ifid_flush(o2[4]), .idex_nop(o2[3]),
      .idex_stall(o2[2]), .exmem_stall(o2[1]), .halted(o2[0]));

   localparam logic [6:0] STALL  = 7'b1101000;
   localparam logic [6:0] FLUSH  = 7'b0011000;
   localparam logic [6:0] FREEZE = 7'b1100110;

   function automatic logic [6:0] model_out(int k);
      logic [6:0] r;
      if (!rst_n)                                r = 7'b0;
      else if (hm[k])                            r = {STALL[6:2], mem_busy, 1'b1};
      else if (mem_busy)                         r = FREEZE;
      else if (drn[k] > 0)                       r = STALL;
      else if (br_taken)                         r = FLUSH;
      else if (bub[k] > 0 || ld_hazard || d_halt) r = STALL;
      else                                       r = 7'b0;
      return r;
   endfunction

   task automatic model_tick(int k);
      if (!rst_n) begin
         bub[k] = 0; drn[k] = 0; hm[k] = 1'b0;
      end else if (hm[k] || mem_busy) begin
      end else if (drn[k] > 0) begin
         drn[k] = drn[k] - 1;
         if (drn[k] == 0) hm[k] = 1'b1;
      end else if (br_taken)   bub[k] = 0;
      else if (bub[k] > 0)     bub[k] = bub[k] - 1;
      else if (ld_hazard)      bub[k] = lb[k] - 1;
      else if (d_halt)         drn[k] = dc[k];
   endtask

   task automatic check_all(input string tag);
      logic [6:0] obs, exp;
      for (int k = 0; k < 3; k++) begin
         obs = (k == 0) ? o0 : (k == 1) ? o1 : o2;
         exp = model_out(k);
         tests++;
         assert (obs === exp) else begin
            fails++;
            $error("FAIL %s inst%0d cycle %0d: observed %b expected %b", tag, k, cyc, obs, exp);
         end
      end
   endtask

   // Apply inputs just after a rising edge, check mid-cycle, then advance one clock.
   task automatic step(input logic r, l, b, m, h, input string tag);
      rst_n = r; ld_hazard = l; br_taken = b; mem_busy = m; d_halt = h;
      #2;
      check_all(tag);
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_tick(k);
      cyc++;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ld_hazard = 1'b0; br_taken = 1'b0; mem_busy = 1'b0; d_halt = 1'b0;
      for (int k = 0; k < 3; k++) begin bub[k] = 0; drn[k] = 0; hm[k] = 1'b0; end
      #1;
      check_all("reset");
      @(posedge clk); #1;

      // Load-use bubbles, one hazard cycle
      step(1, 1, 0, 0, 0, "ld_start");
      repeat (4) step(1, 0, 0, 0, 0, "ld_bubble");

      // Branch beats a same-cycle hazard
      step(1, 1, 1, 0, 0, "br_vs_ld");
      step(1, 0, 0, 0, 0, "br_after");

      // Branch in the second LDSTALL cycle
      step(1, 1, 0, 0, 0, "ld2_start");
      step(1, 0, 0, 0, 0, "ld2_mid");
      step(1, 0, 1, 0, 0, "ld2_br");
      repeat (2) step(1, 0, 0, 0, 0, "ld2_after");

      // mem_busy stretches a bubble sequence
      step(1, 1, 0, 0, 0, "mb_ld");
      repeat (4) step(1, 0, 0, 1, 0, "mb_freeze");
      repeat (3) step(1, 0, 0, 0, 0, "mb_resume");

      // Async reset asserted mid-LDSTALL with conflicting inputs
      step(1, 1, 0, 0, 0, "rst_ld");
      ld_hazard = 1'b1; br_taken = 1'b1; rst_n = 1'b0;
      #1;
      check_all("rst_async");
      step(0, 1, 1, 0, 0, "rst_hold");
      step(1, 0, 0, 0, 0, "rst_release");
      step(1, 1, 0, 0, 0, "rst_run_ld");
      repeat (3) step(1, 0, 0, 0, 0, "rst_run_idle");

      // Halt drain, then halted is sticky against further requests
      step(1, 0, 0, 0, 1, "halt_dec");
      repeat (3) step(1, 0, 0, 0, 0, "halt_drain");
      step(1, 0, 1, 0, 0, "halt_br");
      step(1, 1, 0, 0, 0, "halt_ld");
      step(1, 0, 0, 1, 0, "halt_mb");
      step(1, 0, 0, 0, 1, "halt_idle");
      step(0, 0, 0, 0, 0, "halt_rst");

      // Halt drain stretched by mem_busy
      step(1, 0, 0, 0, 1, "halt2_dec");
      step(1, 0, 0, 1, 0, "halt2_mb");
      repeat (4) step(1, 0, 0, 0, 0, "halt2_drain");
      step(0, 0, 0, 0, 0, "halt2_rst");

      // Randomised traffic with occasional halts and resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 149) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 39) == 0),
              "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
